// File: rtl/layer_sequencer.sv
// One fully-connected layer: per-neuron MAC over streamed activations/weights,
// saturating ReLU, and a valid/ready result stream.
module layer_sequencer #(
  parameter int NUM_INPUTS      = 784,
  parameter int NUM_NEURONS     = 16,
  parameter int sumWidth        = 32,
  parameter int sumFracWidth    = 17,
  parameter int dataWidth       = 16,
  parameter int dataIntWidth    = 6,
  parameter int weightWidth     = 8,
  parameter int weightFracWidth = 7,
  parameter int IW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int WAW = (NUM_INPUTS * NUM_NEURONS > 1) ? $clog2(NUM_INPUTS * NUM_NEURONS) : 1,
  parameter int NW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   data_en,
  output logic [IW-1:0]          data_addr,
  input  logic [dataWidth-1:0]   data_rd,
  output logic                   wgt_en,
  output logic [WAW-1:0]         wgt_addr,
  input  logic [weightWidth-1:0] wgt_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NW-1:0]          out_idx,
  output logic [dataWidth-1:0]   out_data
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_MAC   | issuing read for input i, accumulating product of input i-1
  // S_DRAIN | accumulating the final product
  // S_ACT   | registering ReLU(acc) and neuron index
  // S_OUT   | presenting result, waiting for out_ready
  // S_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_ACT, S_OUT, S_DONE} state_t;

  localparam int PW = dataWidth + weightWidth;
  localparam logic [IW-1:0] LAST_I = IW'(NUM_INPUTS - 1);
  localparam logic [NW-1:0] LAST_N = NW'(NUM_NEURONS - 1);
  localparam logic [sumWidth-1:0] SAT_TH =
    sumWidth'((longint'(1) << (dataIntWidth + sumFracWidth - 1)) - 1);
  localparam logic [dataWidth-1:0] MAX_POS = {1'b0, {(dataWidth-1){1'b1}}};

  state_t                 state_q, state_d;
  logic [sumWidth-1:0]    acc_q, acc_d;
  logic [IW-1:0]          i_q, i_d;
  logic [NW-1:0]          n_q, n_d;
  logic [dataWidth-1:0]   out_data_q, out_data_d;
  logic [NW-1:0]          out_idx_q, out_idx_d;

  logic signed [PW-1:0]   prod;
  logic [sumWidth-1:0]    prod_ext;
  logic [dataWidth-1:0]   relu;
  logic                   mem_en;

  assign prod     = PW'($signed(data_rd)) * PW'($signed(wgt_rd));
  assign prod_ext = sumWidth'(prod);

  // Non-negative acc: clamp at the Q6.10 maximum, otherwise drop 7 fraction bits.
  always_comb begin
    relu = acc_q[dataWidth+weightFracWidth-1 : weightFracWidth];
    if (acc_q[sumWidth-1])
      relu = '0;
    else if (acc_q >= SAT_TH)
      relu = MAX_POS;
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    i_d        = i_q;
    n_d        = n_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    busy       = 1'b1;
    done       = 1'b0;
    out_valid  = 1'b0;
    mem_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_MAC;
          acc_d   = '0;
          i_d     = '0;
          n_d     = '0;
        end
      end
      S_MAC: begin
        mem_en = 1'b1;
        if (i_q != '0)
          acc_d = acc_q + prod_ext;
        if (i_q == LAST_I)
          state_d = S_DRAIN;
        else
          i_d = i_q + IW'(1);
      end
      S_DRAIN: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_ACT;
      end
      S_ACT: begin
        out_data_d = relu;
        out_idx_d  = n_q;
        state_d    = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (n_q == LAST_N) begin
            state_d = S_DONE;
          end else begin
            n_d     = n_q + NW'(1);
            acc_d   = '0;
            i_d     = '0;
            state_d = S_MAC;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      i_q        <= '0;
      n_q        <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      n_q        <= n_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end

  assign data_en   = mem_en;
  assign wgt_en    = mem_en;
  assign data_addr = i_q;
  assign wgt_addr  = WAW'(n_q) * WAW'(NUM_INPUTS) + WAW'(i_q);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with NUM_INPUTS=4, NUM_NEURONS=2 and
// synchronous RAM models for activations and weights.
module tb_layer_sequencer;
  localparam int NI = 4;
  localparam int NN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, data_en, wgt_en, out_valid;
  logic [1:0]  data_addr;
  logic [2:0]  wgt_addr;
  logic [15:0] data_rd = '0;
  logic [7:0]  wgt_rd = '0;
  logic [0:0]  out_idx;
  logic [15:0] out_data;

  logic [15:0] dmem [NI];
  logic [7:0]  wmem [NI*NN];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_v, done_n, done_rel;
  logic [15:0] tr_data[$];
  int tr_idx[$];
  int tr_rel[$];
  int dq[$];
  int wq[$];

  layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .data_en(data_en), .data_addr(data_addr), .data_rd(data_rd),
    .wgt_en(wgt_en), .wgt_addr(wgt_addr), .wgt_rd(wgt_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (data_en) data_rd <= dmem[data_addr];
    if (wgt_en)  wgt_rd  <= wmem[wgt_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    tr_data.delete(); tr_idx.delete(); tr_rel.delete(); dq.delete(); wq.delete();
    first_v = -1; done_n = 0; done_rel = -1;
  endtask

  // Sample mid-cycle, then advance past the next rising edge.
  task automatic tick();
    int rel;
    @(negedge clk);
    rel = cyc - start_cyc;
    if (out_valid && first_v < 0) first_v = rel;
    if (out_valid && out_ready) begin
      tr_data.push_back(out_data);
      tr_idx.push_back(int'(out_idx));
      tr_rel.push_back(rel);
    end
    if (done) begin done_n++; done_rel = rel; end
    if (data_en) dq.push_back(int'(data_addr));
    if (wgt_en)  wq.push_back(int'(wgt_addr));
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run(input bit repulse);
    int rel;
    clear_logs();
    start_cyc = cyc;
    start = 1'b1;
    for (int k = 0; k < 200 && done_n == 0; k++) begin
      tick();
      rel = cyc - start_cyc;
      start = repulse && (rel == 3 || rel == 10 || rel == 15);
    end
    start = 1'b0;
  endtask

  task automatic check_layer(input string tag, input logic [15:0] e0, input logic [15:0] e1);
    check({tag, "_ntr"}, tr_data.size(), 2);
    check({tag, "_done"}, done_n, 1);
    if (tr_data.size() == 2) begin
      check({tag, "_idx0"}, tr_idx[0], 0);
      check({tag, "_d0"}, tr_data[0], e0);
      check({tag, "_idx1"}, tr_idx[1], 1);
      check({tag, "_d1"}, tr_data[1], e1);
    end
  endtask

  task automatic load(input logic [15:0] d0, d1, d2, d3,
                      input logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7);
    dmem[0] = d0; dmem[1] = d1; dmem[2] = d2; dmem[3] = d3;
    wmem[0] = w0; wmem[1] = w1; wmem[2] = w2; wmem[3] = w3;
    wmem[4] = w4; wmem[5] = w5; wmem[6] = w6; wmem[7] = w7;
  endtask

  initial begin
    logic [15:0] held_d;
    logic [0:0]  held_i;
    int k;
    clear_logs();
    load(16'h0400, 16'h0400, 16'h0400, 16'h0400,
         8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
    #2;
    check("rst_flags", {busy, done, out_valid, data_en, wgt_en}, 5'b0);
    check("rst_out", {15'b0, out_idx, out_data}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: all 1.0 x 0.5 -> 2.0 on both neurons, with latency and addresses
    run(1'b0);
    check_layer("t1", 16'h0800, 16'h0800);
    check("t1_first_valid", first_v, 7);
    if (tr_rel.size() == 2) check("t1_valid2", tr_rel[1], 14);
    check("t1_done_cyc", done_rel, 15);
    check("t1_idle", busy, 1'b0);
    check("t1_naddr", dq.size() + wq.size(), 16);
    if (dq.size() == 8 && wq.size() == 8)
      for (int a = 0; a < 8; a++) begin
        check($sformatf("t1_daddr%0d", a), dq[a], a % 4);
        check($sformatf("t1_waddr%0d", a), wq[a], a);
      end

    // 2: negative sum clamps to zero
    load(16'h0400, 16'h0400, 16'h0400, 16'h0400,
         8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40, 8'h40, 8'h40, 8'h40);
    run(1'b0);
    check_layer("t2", 16'h0000, 16'h0800);

    // 3: saturation, small-value truncation, and mixed signs
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
         8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    run(1'b0);
    check_layer("t3sat", 16'h7FFF, 16'h7FFF);
    load(16'h0001, 16'h0001, 16'h0001, 16'h0001,
         8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01);
    run(1'b0);
    check_layer("t3trunc", 16'h0000, 16'h0000);
    // n0: 65536+16384-16384+32639=98175 -> 766; n1: 65536+32768+65536+771=164611 -> 1286
    load(16'h0400, 16'h0200, 16'hFC00, 16'h0101,
         8'h40, 8'h20, 8'h10, 8'h7F, 8'h40, 8'h40, 8'hC0, 8'h03);
    run(1'b0);
    check_layer("t3mix", 16'h02FE, 16'h0506);

    // 4: back-pressure on idx0
    load(16'h0400, 16'h0400, 16'h0400, 16'h0400,
         8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
    clear_logs();
    out_ready = 1'b0;
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin tick(); k++; end
    check("t4_reach_valid", out_valid, 1'b1);
    held_d = out_data;
    held_i = out_idx;
    check("t4_held_d0", held_d, 16'h0800);
    for (int s = 0; s < 5; s++) begin
      tick();
      check($sformatf("t4_stall%0d", s), {out_valid, out_idx, out_data, data_en, wgt_en},
            {1'b1, held_i, held_d, 2'b00});
    end
    out_ready = 1'b1;
    for (int j = 0; j < 200 && done_n == 0; j++) tick();
    check_layer("t4", 16'h0800, 16'h0800);
    check("t4_naddr", dq.size() + wq.size(), 16);

    // 5a: start re-pulsed while busy is ignored
    run(1'b1);
    check_layer("t5rep", 16'h0800, 16'h0800);
    check("t5rep_idle", busy, 1'b0);
    tick();
    check("t5rep_idle2", busy, 1'b0);

    // 5b: reset during idx1 MAC abandons the layer
    clear_logs();
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    check("t5rst_pre", {data_en, out_data}, {1'b1, 16'h0800});
    rst_n = 1'b0;
    #1;
    check("t5rst_flags", {busy, done, out_valid, data_en, wgt_en}, 5'b0);
    check("t5rst_out", {15'b0, out_idx, out_data}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("t5rst_nodone", done_n, 0);
    check("t5rst_one_out", tr_data.size(), 1);
    run(1'b0);
    check_layer("t5fresh", 16'h0800, 16'h0800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
